data_sync: RTL and testbench
============================

// Module: data_sync
// PURPOSE
//  Clock-domain-crossing receiver for a multi-bit bus qualified by a single enable.
//  - bus_en arrives from a foreign clock domain and passes through an N-flop synchronizer.
//  - A rising edge of the synchronized enable produces a one-cycle pulse.
//  - That pulse captures async_bus into sync_bus and drives en_pulse.
//  - Sits at the receive side of every bus crossing, for example into the register file or ALU domain.
// PARAMETERS
//  WIDTH   8  width of async_bus / sync_bus
//  stages  2  number of synchronizer flops on bus_en (legal >= 2; elaboration error otherwise)
// PORTS
//  clk        in   1      destination-domain clock; all flops on posedge
//  rst        in   1      reset, synchronous and active-low
//  async_bus  in   WIDTH  data from source domain; required stable while bus_en is high
//  bus_en     in   1      source-domain data-valid level, asynchronous to clk
//  en_pulse   out  1      registered one-cycle strobe: sync_bus was just updated
//  sync_bus   out  WIDTH  registered captured data, held between captures
// BEHAVIOUR
//  Reset
//  - Reset is synchronous and active-low.
//  - On any posedge with rst==0, all flops clear: sync chain, edge flop, en_pulse=0, sync_bus=0.
//  - Reset overrides all other activity, including mid-transfer.
//  - Any partially synchronized enable is discarded; no pulse is emitted for it after release.
//  Sync chain
//  - sync_reg[stages-1:0] shifts bus_en in at bit 0 each cycle.
//  - sync_out = sync_reg[stages-1].
//  Edge detect
//  - pulse_ff <= sync_out.
//  - pulse = sync_out & ~pulse_ff (combinational).
//  Capture
//  - On each posedge, en_pulse <= pulse.
//  - If pulse: sync_bus <= async_bus. Otherwise sync_bus holds.
//  - The bus itself is not synchronized; source-side stability is the CDC guarantee.
//  Latency
//  - bus_en first sampled high at edge k -> sync_out high after edge k+stages-1.
//  - en_pulse=1 and sync_bus updated after edge k+stages.
//  - That is, stages+1 edges from the first sampling edge (3 edges at default).
//  - en_pulse stays high exactly one cycle, however long bus_en stays high.
//  Boundary cases
//  - bus_en held high continuously: exactly one pulse, then none.
//  - bus_en high at reset release: counts as a rising edge; one pulse occurs.
//  - bus_en low for 1 cycle, then high again: a new pulse (the low propagates through the chain).
//  - bus_en low for less than 1 cycle, or a glitch: may be missed. No pulse is required; no double pulse is allowed.
//  - Falling edge of bus_en: no pulse; sync_bus holds.
//  - async_bus changing while bus_en is high: no effect after the capture cycle.
// STRUCTURE
//  - No shared package is needed; both parameters stay local.
//  - One natural sub-module: bit_sync (parameterized 1-bit N-stage synchronizer, same clk/rst), instantiated for bus_en.
//  - Edge detect and capture registers stay in data_sync.
//  - No other state machine.
// TESTING
//  - Reset: hold rst=0 for 2 edges -> en_pulse=0, sync_bus=8'h00.
//  - Assert at reset: bus_en=1, async_bus=8'hEC at release -> en_pulse=1 after the 3rd edge for exactly 1 cycle; sync_bus=8'hEC thereafter.
//  - Hold bus_en=1 for 10 cycles -> no further pulses; sync_bus stays 8'hEC.
//  - Repeated transfers: bus_en=0 for 1 cycle, then async_bus=8'h24, bus_en=1 for 3 cycles; repeat 16 times with random data -> exactly one pulse per window, sync_bus equals that window's data.
//  - Reset during transfer: drop rst in the cycle after bus_en rises -> no pulse; outputs 0.
//  - stages=3: re-run the assert-at-reset case -> pulse after the 4th edge.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared elaboration constants for the data_sync bus-crossing receiver.
package data_sync_pkg;

  // Fewer than two flops gives no meaningful metastability settling time.
  localparam int unsigned MinStages = 2;

endpackage

// File: rtl/data_sync_bit_sync.sv
// Single-bit N-flop synchronizer with synchronous active-low reset.
module bit_sync
  import data_sync_pkg::*;
#(
  parameter int unsigned stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  if (stages < MinStages) begin : g_bad_stages
    $error("bit_sync: stages must be >= 2");
  end

  logic [stages-1:0] sync_q;
  logic [stages-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[stages-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[stages-1];

endmodule

// File: rtl/data_sync.sv
// Receive side of a bus crossing: synchronizes bus_en, strobes on its rising
// edge and captures async_bus (held stable by the source) on that strobe.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_bus,
  input  logic             bus_en,
  output logic             en_pulse,
  output logic [WIDTH-1:0] sync_bus
);

  if (stages < MinStages) begin : g_bad_stages
    $error("data_sync: stages must be >= 2");
  end

  logic             sync_out;
  logic             pulse;
  logic             pulse_ff_q, pulse_ff_d;
  logic             en_pulse_q, en_pulse_d;
  logic [WIDTH-1:0] sync_bus_q, sync_bus_d;

  bit_sync #(
    .stages(stages)
  ) u_en_sync (
    .clk(clk),
    .rst(rst),
    .d_i(bus_en),
    .q_o(sync_out)
  );

  always_comb begin
    pulse      = sync_out & ~pulse_ff_q;
    pulse_ff_d = sync_out;
    en_pulse_d = pulse;
    sync_bus_d = sync_bus_q;
    if (pulse) begin
      sync_bus_d = async_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pulse_ff_q <= 1'b0;
      en_pulse_q <= 1'b0;
      sync_bus_q <= '0;
    end else begin
      pulse_ff_q <= pulse_ff_d;
      en_pulse_q <= en_pulse_d;
      sync_bus_q <= sync_bus_d;
    end
  end

  assign en_pulse = en_pulse_q;
  assign sync_bus = sync_bus_q;

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: directed vector table, randomized transfer windows and
// a reset-mid-transfer sequence, checked against a sample-history model.
module tb_data_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] async_bus;
  logic       bus_en;
  logic       en_pulse2, en_pulse3;
  logic [7:0] sync_bus2, sync_bus3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_sync dut2 (
    .clk(clk),
    .rst(rst),
    .async_bus(async_bus),
    .bus_en(bus_en),
    .en_pulse(en_pulse2),
    .sync_bus(sync_bus2)
  );

  data_sync #(
    .WIDTH(8),
    .stages(3)
  ) dut3 (
    .clk(clk),
    .rst(rst),
    .async_bus(async_bus),
    .bus_en(bus_en),
    .en_pulse(en_pulse3),
    .sync_bus(sync_bus3)
  );

  // Model: every bus_en sample since reset release. The strobe after edge n
  // fires when the sample taken `stages` edges earlier is high and the one
  // before it is low; samples from before release count as low.
  bit         en_hist[$];
  logic       exp_p2, exp_p3;
  logic [7:0] exp_b2, exp_b3;

  function automatic bit hist_at(int i);
    if (i >= 0 && i < en_hist.size()) return en_hist[i];
    return 1'b0;
  endfunction

  function automatic bit rise_seen(int s);
    int n;
    n = en_hist.size() - 1;
    return hist_at(n - s) && !hist_at(n - s - 1);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      en_hist.delete();
      exp_p2 = 1'b0;
      exp_p3 = 1'b0;
      exp_b2 = 8'h00;
      exp_b3 = 8'h00;
    end else begin
      en_hist.push_back(bus_en);
      exp_p2 = rise_seen(2);
      exp_p3 = rise_seen(3);
      if (exp_p2) exp_b2 = async_bus;
      if (exp_p3) exp_b3 = async_bus;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive for one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] b);
    rst       = r;
    bus_en    = e;
    async_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " en_pulse s2"}, {31'b0, en_pulse2}, {31'b0, exp_p2});
    check({tag, " sync_bus s2"}, {24'b0, sync_bus2}, {24'b0, exp_b2});
    check({tag, " en_pulse s3"}, {31'b0, en_pulse3}, {31'b0, exp_p3});
    check({tag, " sync_bus s3"}, {24'b0, sync_bus3}, {24'b0, exp_b3});
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] b;
    logic       p2;
    logic [7:0] b2;
    logic       p3;
    logic [7:0] b3;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic r, logic e, logic [7:0] b, logic p2, logic [7:0] b2,
                              logic p3, logic [7:0] b3);
    vec_t v;
    v.r = r; v.e = e; v.b = b; v.p2 = p2; v.b2 = b2; v.p3 = p3; v.b3 = b3;
    return v;
  endfunction

  initial begin
    logic [7:0] data;
    int         pulses;

    rst       = 1'b0;
    bus_en    = 1'b0;
    async_bus = 8'h00;
    #1;

    // Reset, bus_en already high at release, long hold, bus change, fall.
    vecs[0] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[1] = mk(0, 1, 8'hEC, 0, 8'h00, 0, 8'h00);
    vecs[2] = mk(1, 1, 8'hEC, 0, 8'h00, 0, 8'h00);
    vecs[3] = mk(1, 1, 8'hEC, 0, 8'h00, 0, 8'h00);
    vecs[4] = mk(1, 1, 8'hEC, 1, 8'hEC, 0, 8'h00);
    vecs[5] = mk(1, 1, 8'hEC, 0, 8'hEC, 1, 8'hEC);
    for (int i = 6; i < 15; i++) vecs[i] = mk(1, 1, 8'hEC, 0, 8'hEC, 0, 8'hEC);
    vecs[15] = mk(1, 1, 8'h55, 0, 8'hEC, 0, 8'hEC);
    for (int i = 16; i < 19; i++) vecs[i] = mk(1, 0, 8'h55, 0, 8'hEC, 0, 8'hEC);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].b);
      check($sformatf("vec%0d en_pulse s2", i), {31'b0, en_pulse2}, {31'b0, vecs[i].p2});
      check($sformatf("vec%0d sync_bus s2", i), {24'b0, sync_bus2}, {24'b0, vecs[i].b2});
      check($sformatf("vec%0d en_pulse s3", i), {31'b0, en_pulse3}, {31'b0, vecs[i].p3});
      check($sformatf("vec%0d sync_bus s3", i), {24'b0, sync_bus3}, {24'b0, vecs[i].b3});
    end

    // Repeated transfers: one low cycle then three high cycles of fresh data.
    for (int w = 0; w < 16; w++) begin
      data   = 8'($urandom_range(0, 255));
      pulses = 0;
      step(1, 0, 8'($urandom_range(0, 255)));
      check_model($sformatf("win%0d low", w));
      pulses += int'(en_pulse2);
      for (int c = 0; c < 3; c++) begin
        step(1, 1, data);
        check_model($sformatf("win%0d hi%0d", w, c));
        pulses += int'(en_pulse2);
      end
      check($sformatf("win%0d pulse count", w), pulses, 1);
      check($sformatf("win%0d data", w), {24'b0, sync_bus2}, {24'b0, data});
    end

    // Reset in the cycle after bus_en rises: nothing may emerge afterwards.
    for (int c = 0; c < 4; c++) step(1, 0, 8'hA5);
    step(1, 1, 8'h3C);
    step(0, 0, 8'h3C);
    for (int c = 0; c < 6; c++) begin
      step(1, 0, 8'h3C);
      check($sformatf("rstmid%0d en_pulse s2", c), {31'b0, en_pulse2}, 32'd0);
      check($sformatf("rstmid%0d sync_bus s2", c), {24'b0, sync_bus2}, 32'd0);
      check_model($sformatf("rstmid%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
